wb_slave_decoder: RTL and testbench

// Routes one Wishbone master (normally the output of the bus arbiter) to one of N slaves,

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_watchdog.sv | 36 +++
 rtl/wb_slave_decoder.sv | 126 ++++++++++++
 tb/tb_wb_slave_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone slave decoder.
package wb_pkg;

  // Decoder FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam int unsigned STATE_WIDTH = 2;

  // Low bit of slave idx's word inside a packed per-slave bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Saturating wait-cycle counter; expired flags the last allowed wait cycle.
module wb_watchdog #(
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/wb_slave_decoder.sv
// Routes one Wishbone master to one of N slaves; watchdog turns hangs and holes into mErrO.
module wb_slave_decoder
  import wb_pkg::*;
#(
  parameter int unsigned                      SLAVES_WIDTH  = 2,
  parameter int unsigned                      ADDRESS_WIDTH = 32,
  parameter int unsigned                      DATA_WIDTH    = 32,
  parameter logic [(1 << SLAVES_WIDTH)-1:0]   SLAVE_PRESENT = 4'b1111,
  parameter int unsigned                      TIMEOUT       = 255,
  parameter int unsigned                      TIMEOUT_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      mCycI,
  input  logic                                      mStbI,
  input  logic                                      mWeI,
  input  logic [ADDRESS_WIDTH-1:0]                  mAdrI,
  input  logic [DATA_WIDTH-1:0]                     mDatI,
  output logic [DATA_WIDTH-1:0]                     mDatO,
  output logic                                      mAckO,
  output logic                                      mErrO,
  output logic [(1 << SLAVES_WIDTH)-1:0]            sCycO,
  output logic [(1 << SLAVES_WIDTH)-1:0]            sStbO,
  output logic                                      sWeO,
  output logic [ADDRESS_WIDTH-1:0]                  sAdrO,
  output logic [DATA_WIDTH-1:0]                     sDatO,
  input  logic [(1 << SLAVES_WIDTH)-1:0]            sAckI,
  input  logic [DATA_WIDTH*(1 << SLAVES_WIDTH)-1:0] sDatIPacked
);

  localparam int unsigned SLAVES_COUNT = 1 << SLAVES_WIDTH;

  state_e                  state_q, state_d;
  logic [SLAVES_WIDTH-1:0] sel_q, sel_d;
  logic                    err_q, err_d;
  logic [SLAVES_WIDTH-1:0] dec_idx;
  logic                    sel_ack;
  logic                    wd_clear, wd_tick, wd_expired;
  logic [DATA_WIDTH-1:0]   slave_dat [SLAVES_COUNT];

  // Address and write data are broadcast unchanged.
  assign sAdrO   = mAdrI;
  assign sDatO   = mDatI;
  assign dec_idx = mAdrI[ADDRESS_WIDTH-1 -: SLAVES_WIDTH];
  assign sel_ack = sAckI[sel_q];

  // Unpack per-slave read data.
  for (genvar i = 0; i < SLAVES_COUNT; i++) begin : g_unpack
    assign slave_dat[i] = sDatIPacked[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
  end

  wb_watchdog #(
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  // Next state, slave steering and master response.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    sCycO    = '0;
    sStbO    = '0;
    sWeO     = 1'b0;
    mAckO    = 1'b0;
    mDatO    = '0;
    wd_tick  = 1'b0;
    wd_clear = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (mCycI && mStbI) begin
          if (SLAVE_PRESENT[dec_idx]) begin
            sel_d   = dec_idx;
            state_d = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACTIVE: begin
        sCycO[sel_q] = mCycI;
        sStbO[sel_q] = mStbI;
        sWeO         = mWeI;
        mAckO        = sel_ack && mStbI;
        mDatO        = slave_dat[sel_q];
        wd_tick      = mStbI && !sel_ack;
        wd_clear     = !wd_tick;
        if (!mCycI) begin
          state_d = ST_IDLE;
        end else if (wd_tick && wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (!mCycI) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, locked slave index and one-shot error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign mErrO = err_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Bench for wb_slave_decoder: directed scenarios plus random traffic against a transaction model.
module tb_wb_slave_decoder;

  localparam int unsigned SW      = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SC      = 4;
  localparam int          TO      = 4;
  localparam int unsigned TW      = 8;
  localparam logic [3:0]  PRESENT = 4'b0111;

  logic             clk, rst;
  logic             mCycI, mStbI, mWeI;
  logic [AW-1:0]    mAdrI;
  logic [DW-1:0]    mDatI, mDatO;
  logic             mAckO, mErrO;
  logic [SC-1:0]    sCycO, sStbO, sAckI;
  logic             sWeO;
  logic [AW-1:0]    sAdrO;
  logic [DW-1:0]    sDatO;
  logic [DW*SC-1:0] sDatIPacked;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: which slave owns the bus (-1 none, -2 faulted), consecutive unacked waits, error pulse.
  int m_owner = -1;
  int m_waits = 0;
  bit m_err   = 1'b0;

  wb_slave_decoder #(
    .SLAVES_WIDTH  (SW),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .SLAVE_PRESENT (PRESENT),
    .TIMEOUT       (TO),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mCycI       (mCycI),
    .mStbI       (mStbI),
    .mWeI        (mWeI),
    .mAdrI       (mAdrI),
    .mDatI       (mDatI),
    .mDatO       (mDatO),
    .mAckO       (mAckO),
    .mErrO       (mErrO),
    .sCycO       (sCycO),
    .sStbO       (sStbO),
    .sWeO        (sWeO),
    .sAdrO       (sAdrO),
    .sDatO       (sDatO),
    .sAckI       (sAckI),
    .sDatIPacked (sDatIPacked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [SC-1:0] ack);
    mCycI = c;
    mStbI = s;
    mWeI  = w;
    mAdrI = a;
    sAckI = ack;
  endtask

  // Transaction model advanced on each clock edge.
  always @(posedge clk) begin
    m_err <= 1'b0;
    if (rst) begin
      m_owner <= -1;
      m_waits <= 0;
    end else if (m_owner == -1) begin
      if (mCycI && mStbI) begin
        if (PRESENT[mAdrI[AW-1 -: SW]]) begin
          m_owner <= int'(mAdrI[AW-1 -: SW]);
          m_waits <= 0;
        end else begin
          m_owner <= -2;
          m_err   <= 1'b1;
        end
      end
    end else if (m_owner >= 0) begin
      if (!mCycI) begin
        m_owner <= -1;
      end else if (mStbI && !sAckI[m_owner]) begin
        if (m_waits + 1 == TO) begin
          m_owner <= -2;
          m_err   <= 1'b1;
        end else begin
          m_waits <= m_waits + 1;
        end
      end else begin
        m_waits <= 0;
      end
    end else if (!mCycI) begin
      m_owner <= -1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [SC-1:0] e_cyc, e_stb;
    logic          e_we, e_ack;
    logic [DW-1:0] e_dat;
    if (check_en) begin
      e_cyc = '0;
      e_stb = '0;
      for (int i = 0; i < SC; i++) begin
        e_cyc[i] = (m_owner == i) && mCycI;
        e_stb[i] = (m_owner == i) && mStbI;
      end
      e_we  = (m_owner >= 0) && mWeI;
      e_ack = (m_owner >= 0) ? (sAckI[m_owner] && mStbI) : 1'b0;
      e_dat = (m_owner >= 0) ? sDatIPacked[m_owner*DW +: DW] : '0;
      chk("m_sCycO", 64'(sCycO), 64'(e_cyc));
      chk("m_sStbO", 64'(sStbO), 64'(e_stb));
      chk("m_sWeO",  64'(sWeO),  64'(e_we));
      chk("m_mAckO", 64'(mAckO), 64'(e_ack));
      chk("m_mErrO", 64'(mErrO), 64'(m_err));
      chk("m_mDatO", 64'(mDatO), 64'(e_dat));
      chk("m_sAdrO", 64'(sAdrO), 64'(mAdrI));
      chk("m_sDatO", 64'(sDatO), 64'(mDatI));
      chk("m_ack_err_excl", 64'(mAckO & mErrO), 64'd0);
    end
  end

  initial begin
    int acks;
    rst = 1'b1;
    mDatI = 32'h1234_5678;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    sDatIPacked = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    next();
    check_en = 1'b1;
    look();
    chk("rst_scyc", 64'(sCycO), 64'd0);
    chk("rst_sstb", 64'(sStbO), 64'd0);
    chk("rst_merr", 64'(mErrO), 64'd0);
    chk("rst_mack", 64'(mAckO), 64'd0);
    next();
    rst = 1'b0;

    // Write to slave 2, ACK on the third strobed cycle.
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0010, 4'b0000);
    look(); chk("t1_c0_stb", 64'(sStbO), 64'd0); next();
    for (int c = 1; c <= 2; c++) begin
      look();
      chk("t1_stb", 64'(sStbO), 64'h4);
      chk("t1_cyc", 64'(sCycO), 64'h4);
      chk("t1_we",  64'(sWeO),  64'd1);
      chk("t1_ack_wait", 64'(mAckO), 64'd0);
      next();
    end
    sAckI = 4'b0100;
    look(); chk("t1_ack", 64'(mAckO), 64'd1); chk("t1_err", 64'(mErrO), 64'd0); next();
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0010, 4'b0000);
    look(); chk("t1_ack_drop", 64'(mAckO), 64'd0); chk("t1_stb_drop", 64'(sStbO), 64'd0); next();
    look(); chk("t1_idle_cyc", 64'(sCycO), 64'd0); next();

    // Four-beat read from slave 1; address moves to slave 3 mid-burst.
    drive(1'b1, 1'b1, 1'b0, 32'h4000_0000, 4'b0000);
    next();
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      sAckI = 4'b1010;
      if (b == 1) mAdrI = 32'hC000_0000;
      look();
      chk("t2_cyc", 64'(sCycO), 64'h2);
      chk("t2_dat", 64'(mDatO), 64'hBBBB_0001);
      if (mAckO) acks++;
      next();
    end
    drive(1'b0, 1'b0, 1'b0, 32'hC000_0000, 4'b0000);
    look(); if (mAckO) acks++; chk("t2_acks", 64'(acks), 64'd4); next();
    next();

    // Unmapped slave 3: one error pulse, no strobe.
    drive(1'b1, 1'b1, 1'b0, 32'hC000_0000, 4'b0000);
    look(); chk("t3_c0_err", 64'(mErrO), 64'd0); next();
    look(); chk("t3_err", 64'(mErrO), 64'd1); chk("t3_stb", 64'(sStbO), 64'd0); next();
    for (int c = 0; c < 2; c++) begin
      look(); chk("t3_err_hold", 64'(mErrO), 64'd0); chk("t3_stb_hold", 64'(sStbO), 64'd0); next();
    end
    drive(1'b0, 1'b0, 1'b0, 32'hC000_0000, 4'b0000);
    look(); chk("t3_err_low", 64'(mErrO), 64'd0); next();
    next();

    // Slave 0 never ACKs: error on cycle 5 after STB.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 4'b0000);
    next();
    for (int c = 1; c <= 4; c++) begin
      look(); chk("t4_stb", 64'(sStbO), 64'h1); chk("t4_err_wait", 64'(mErrO), 64'd0); next();
    end
    look(); chk("t4_err", 64'(mErrO), 64'd1); chk("t4_stb_off", 64'(sStbO), 64'd0); next();
    look(); chk("t4_err_once", 64'(mErrO), 64'd0); next();
    drive(1'b0, 1'b0, 1'b0, '0, 4'b0000);
    next(); next();

    // ACK exactly on the fourth wait cycle wins over the timeout.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 4'b0000);
    next();
    for (int c = 1; c <= 3; c++) begin
      look(); chk("t5_ack_wait", 64'(mAckO), 64'd0); next();
    end
    sAckI = 4'b0001;
    look(); chk("t5_ack", 64'(mAckO), 64'd1); chk("t5_err", 64'(mErrO), 64'd0); next();
    drive(1'b0, 1'b0, 1'b0, '0, 4'b0000);
    look(); chk("t5_err_after", 64'(mErrO), 64'd0); next();
    next();

    // Reset in the middle of a transfer, then a clean new decode.
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0000, 4'b0000);
    next();
    look(); chk("t6_stb", 64'(sStbO), 64'h4); next();
    rst = 1'b1;
    look(); chk("t6_stb_pre", 64'(sStbO), 64'h4); next();
    rst = 1'b0;
    mAdrI = 32'h4000_0000;
    look();
    chk("t6_cyc", 64'(sCycO), 64'd0);
    chk("t6_stb_rst", 64'(sStbO), 64'd0);
    chk("t6_we", 64'(sWeO), 64'd0);
    chk("t6_ack", 64'(mAckO), 64'd0);
    chk("t6_err", 64'(mErrO), 64'd0);
    next();
    look(); chk("t6_new_stb", 64'(sStbO), 64'h2); next();
    drive(1'b0, 1'b0, 1'b0, '0, 4'b0000);
    next(); next();

    // Random traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (mCycI) begin
        if ($urandom_range(0, 5) == 0) mCycI = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        mCycI = 1'b1;
        mAdrI = $urandom;
      end
      if ($urandom_range(0, 3) == 0) mAdrI = $urandom;
      mStbI = mCycI && ($urandom_range(0, 9) < 7);
      mWeI  = 1'($urandom_range(0, 1));
      mDatI = $urandom;
      for (int i = 0; i < SC; i++) sAckI[i] = ($urandom_range(0, 99) < 35);
      sDatIPacked = {$urandom, $urandom, $urandom, $urandom};
      next();
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
